chroni_mem_arbiter: RTL
=======================

# chroni_mem_arbiter

Single-port memory arbiter that shares the 8-bit video/character memory between the chroni fetch engine (read-only text and font fetches) and the CPU (read/write). It sits between the requesters' `req`/`ack` handshakes and one synchronous memory port with fixed read latency. Video has fixed priority. A burst limit guarantees the CPU an access slot under sustained video load.

## Interface
- `ADDR_W`, 13: memory address width for both requesters and the memory port.
- `MEM_LATENCY`, 1: cycles from address/strobe issue to valid `mem_rdata`; legal range 1–15.
- `VIDEO_BURST`, 4: maximum consecutive video grants while the CPU is waiting; legal range 1–15.

Ports:
- `sys_clk` in 1: the only clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `vid_addr` in ADDR_W: video fetch address, held stable while `vid_req` is high.
- `vid_req` in 1: video read request, level.
- `vid_ack` out 1: one-cycle pulse; `vid_data` is valid in the same cycle.
- `vid_data` out 8: last video read data, held until the next video ack.
- `cpu_addr` in ADDR_W: CPU address, held stable while `cpu_req` is high.
- `cpu_we` in 1: 1 = write, 0 = read; sampled at grant.
- `cpu_wdata` in 8: write data; sampled at grant.
- `cpu_req` in 1: CPU request, level.
- `cpu_ack` out 1: one-cycle pulse; for reads, `cpu_rdata` is valid in the same cycle.
- `cpu_rdata` out 8: last CPU read data, held; not updated by writes.
- `mem_addr` out ADDR_W: memory address.
- `mem_rd` out 1: read strobe.
- `mem_wr` out 1: write strobe.
- `mem_wdata` out 8: memory write data.
- `mem_rdata` in 8: memory read data, valid `MEM_LATENCY` cycles after issue.
- `busy` out 1: high in every state except IDLE.
- `owner` out 1: 0 = video, 1 = CPU; holds the owner of the current or last access.

## Operation
States: IDLE, BUSY, ACK.

- **IDLE**
  - Grant decision on the clock edge:
    - Only one request high: grant it.
    - Both requests high: grant the CPU if `burst_cnt == VIDEO_BURST`, otherwise grant video.
  - On grant, register `mem_addr`, `owner` and `mem_wdata`; set `mem_rd` (read) or `mem_wr` (CPU write); load `lat_cnt = MEM_LATENCY`; go to BUSY.
  - No request: stay in IDLE.
- **BUSY**
  - `mem_addr` is held for the whole state.
  - Read: `mem_rd` stays high for the whole state.
  - Write: `mem_wr` is high only in the first BUSY cycle.
  - `lat_cnt` decrements each cycle.
  - At `lat_cnt == 1`:
    - On a read, capture `mem_rdata` into `vid_data` or `cpu_rdata` according to `owner`.
    - Clear the strobes and go to ACK.
- **ACK**
  - The owner's ack is high for exactly this cycle.
  - Always go to IDLE next. This gives the requester one edge to drop `req`, so the same request is never granted twice.
- **burst_cnt** (4 bits)
  - Video grant with `cpu_req` high: increment, saturating at `VIDEO_BURST`.
  - CPU grant: clear to 0.
  - Video grant with `cpu_req` low: clear to 0.
- Requesters must hold `req` and their inputs until ack, then drop `req` on the following edge.
  - If `req` drops early, the access still completes and the ack still pulses.
  - The requester must ignore that ack.

## Timing
- Access cost: 1 (IDLE/grant) + `MEM_LATENCY` (BUSY) + 1 (ACK) cycles. With the default latency this is 3 cycles, i.e. at most one access every 3 cycles.
- Latency from `req` asserted in an idle cycle to ack: `MEM_LATENCY + 1` cycles after the grant edge.
- A request that arrives during BUSY or ACK is evaluated at the next IDLE edge. Requests are not queued beyond the levels.
- Video fetch budget: an 80-character text line plus 80 font bytes is 160 accesses, i.e. 480 cycles at the default latency. With CPU contention the worst case is one CPU slot per `VIDEO_BURST` video slots.
- Reset, asynchronous at any point including mid-BUSY:
  - State returns to IDLE.
  - `burst_cnt`, `lat_cnt`, `mem_rd`, `mem_wr`, `vid_ack`, `cpu_ack`, `busy` and `owner` all go to 0.
  - `mem_addr`, `mem_wdata`, `vid_data` and `cpu_rdata` all go to 0.
  - An interrupted access is dropped without an ack; requesters re-request after reset.
- `mem_wr` and `mem_rd` are never high in the same cycle.
- At most one ack is high in any cycle.

## Test plan
- **Isolated video read:** `MEM_LATENCY=1`, memory[0x0401]=0x5A, `vid_req` held with `vid_addr=0x0401`.
  - `mem_rd` is high for 1 cycle; `vid_ack` pulses 2 cycles after the grant edge with `vid_data=0x5A`.
  - `cpu_ack` stays 0.
- **CPU write then read-back:** write 0xC3 to 0x1000, then read 0x1000.
  - Exactly one cycle of `mem_wr` with `mem_wdata=0xC3`.
  - The read returns `cpu_rdata=0xC3`.
  - `cpu_rdata` does not change on the write ack.
- **Sustained contention:** `vid_req` and `cpu_req` both permanently high (each requester re-requests immediately after its ack), `VIDEO_BURST=4`.
  - Grant order is V,V,V,V,C,V,V,V,V,C.
  - `burst_cnt` clears to 0 on each CPU grant.
- **Latency sweep:** `MEM_LATENCY` set to 3.
  - `mem_rd` is high for 3 cycles, `mem_addr` is stable throughout, and the ack is 4 cycles after the grant edge.
  - Data is sampled on the last BUSY cycle; a bench model that changes `mem_rdata` one cycle later must not corrupt the result.
- **Reset mid-access:** assert `reset` during BUSY of a CPU read.
  - All outputs are 0 immediately.
  - No ack ever follows.
  - After deassertion, an immediate `vid_req` is granted on the first edge.
- **Early request drop:** CPU drops `cpu_req` during BUSY.
  - The access completes and `cpu_ack` still pulses once.
  - The next IDLE edge grants a pending `vid_req`.

Source files
------------

// File: rtl/chroni_mem_arbiter.sv
// rtl/chroni_mem_arbiter.sv - video/CPU arbiter for the shared single-port character memory
module chroni_mem_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int MEM_LATENCY = 1,
  parameter int VIDEO_BURST = 4
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              vid_req,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_req,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [3:0] LAT_INIT  = 4'(MEM_LATENCY);
  localparam logic [3:0] BURST_MAX = 4'(VIDEO_BURST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        lat_cnt, lat_cnt_nx;
  logic [3:0]        burst_cnt, burst_cnt_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic              mem_rd_nx, mem_wr_nx;
  logic [7:0]        mem_wdata_nx;
  logic              owner_nx;
  logic [7:0]        vid_data_nx, cpu_rdata_nx;
  logic              vid_ack_nx, cpu_ack_nx;
  logic              grant_vid, grant_cpu;

  assign busy = (state != S_IDLE);

  // Register the whole datapath; everything clears asynchronously so an interrupted access leaves no trace.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      lat_cnt   <= 4'd0;
      burst_cnt <= 4'd0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= 8'd0;
      owner     <= 1'b0;
      vid_data  <= 8'd0;
      cpu_rdata <= 8'd0;
      vid_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
    end else begin
      state     <= state_nx;
      lat_cnt   <= lat_cnt_nx;
      burst_cnt <= burst_cnt_nx;
      mem_addr  <= mem_addr_nx;
      mem_rd    <= mem_rd_nx;
      mem_wr    <= mem_wr_nx;
      mem_wdata <= mem_wdata_nx;
      owner     <= owner_nx;
      vid_data  <= vid_data_nx;
      cpu_rdata <= cpu_rdata_nx;
      vid_ack   <= vid_ack_nx;
      cpu_ack   <= cpu_ack_nx;
    end
  end

  // Grant decision, latency countdown and ack generation; video wins ties until the CPU has waited a full burst.
  always_comb begin
    state_nx     = state;
    lat_cnt_nx   = lat_cnt;
    burst_cnt_nx = burst_cnt;
    mem_addr_nx  = mem_addr;
    mem_rd_nx    = mem_rd;
    mem_wr_nx    = mem_wr;
    mem_wdata_nx = mem_wdata;
    owner_nx     = owner;
    vid_data_nx  = vid_data;
    cpu_rdata_nx = cpu_rdata;
    vid_ack_nx   = 1'b0;
    cpu_ack_nx   = 1'b0;
    grant_vid    = 1'b0;
    grant_cpu    = 1'b0;

    case (state)
      S_IDLE: begin
        grant_cpu = cpu_req && (!vid_req || (burst_cnt == BURST_MAX));
        grant_vid = vid_req && !grant_cpu;
        if (grant_cpu) begin
          mem_addr_nx  = cpu_addr;
          mem_wdata_nx = cpu_wdata;
          owner_nx     = 1'b1;
          mem_rd_nx    = !cpu_we;
          mem_wr_nx    = cpu_we;
          lat_cnt_nx   = LAT_INIT;
          burst_cnt_nx = 4'd0;
          state_nx     = S_BUSY;
        end else if (grant_vid) begin
          mem_addr_nx = vid_addr;
          owner_nx    = 1'b0;
          mem_rd_nx   = 1'b1;
          mem_wr_nx   = 1'b0;
          lat_cnt_nx  = LAT_INIT;
          if (!cpu_req) begin
            burst_cnt_nx = 4'd0;
          end else if (burst_cnt != BURST_MAX) begin
            burst_cnt_nx = burst_cnt + 4'd1;
          end
          state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        // A write strobe only needs one cycle; a read strobe is held until data is captured.
        mem_wr_nx  = 1'b0;
        lat_cnt_nx = lat_cnt - 4'd1;
        if (lat_cnt == 4'd1) begin
          if (mem_rd) begin
            if (owner) begin
              cpu_rdata_nx = mem_rdata;
            end else begin
              vid_data_nx = mem_rdata;
            end
          end
          mem_rd_nx  = 1'b0;
          vid_ack_nx = !owner;
          cpu_ack_nx = owner;
          state_nx   = S_ACK;
        end
      end
      S_ACK: begin
        // One dead edge lets the requester drop req before the next grant decision.
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule
